// File: rtl/pacman_soc_mem_burst_master_if.sv
// Command, write/read stream, status and Avalon-MM signals of the memory burst master.
interface pacman_soc_mem_burst_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [ADDR_W:0]     cmd_len;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_valid;
    logic                wr_ready;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_valid;
    logic                rd_ready;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_writedata;
    logic                avm_clken;
    logic [DATA_W-1:0]   avm_readdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, avm_readdata,
        output cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
               avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata, avm_clken
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, avm_readdata,
        input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
               avm_address, avm_chipselect, avm_write, avm_byteenable, avm_writedata, avm_clken
    );
endinterface

// File: rtl/pacman_soc_mem_burst_master.sv
// Burst master for the on-chip memory: one write or read burst per command, with
// read data returned through a small FIFO whose free space limits outstanding reads.
module pacman_soc_mem_burst_master #(
    parameter int ADDR_W        = 10,
    parameter int DATA_W        = 32,
    parameter int READ_LATENCY  = 1,
    parameter int RD_FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    pacman_soc_mem_burst_master_if.master bus
);
    localparam int PTR_W = $clog2(RD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int INF_W = $clog2(READ_LATENCY + 2);
    localparam int USE_W = CNT_W + 2;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remain_q, remain_d;
    logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
    logic [DATA_W-1:0]   avm_writedata_q, avm_writedata_d;
    logic                avm_chipselect_q, avm_chipselect_d;
    logic                avm_write_q, avm_write_d;
    logic                done_q, done_d;
    logic                drain_done;

    logic [READ_LATENCY-1:0] lat_q, lat_d;
    logic [INF_W-1:0]        inflight;
    logic                    rd_issued;
    logic                    capture;
    logic                    pop;
    logic [USE_W-1:0]        used;

    logic [DATA_W-1:0] fifo_mem [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

    // A read on the bus this cycle is outstanding already; the shift register
    // then carries it until its data is captured READ_LATENCY cycles later.
    assign rd_issued = avm_chipselect_q & ~avm_write_q;
    assign capture   = lat_q[READ_LATENCY-1];
    assign pop       = (fifo_cnt_q != '0) & bus.rd_ready;
    assign used      = USE_W'(fifo_cnt_q) + USE_W'(inflight) - USE_W'(pop);

    always_comb begin
        lat_d    = READ_LATENCY'({lat_q, rd_issued});
        inflight = INF_W'(rd_issued);
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + INF_W'(lat_q[i]);
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(capture);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        fifo_cnt_d = fifo_cnt_q + CNT_W'(capture) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            fifo_mem[wr_ptr_q] <= bus.avm_readdata;
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        remain_d         = remain_q;
        avm_address_d    = avm_address_q;
        avm_writedata_d  = avm_writedata_q;
        avm_chipselect_d = 1'b0;
        avm_write_d      = 1'b0;
        done_d           = 1'b0;
        drain_done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d   = bus.cmd_addr;
                    remain_d = bus.cmd_len;
                    if (bus.cmd_len == '0) begin
                        done_d = 1'b1;
                    end else if (bus.cmd_write) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                if (bus.wr_valid) begin
                    avm_chipselect_d = 1'b1;
                    avm_write_d      = 1'b1;
                    avm_address_d    = addr_q;
                    avm_writedata_d  = bus.wr_data;
                    addr_d           = addr_q + 1'b1;
                    remain_d         = remain_q - 1'b1;
                    if (remain_q == (ADDR_W+1)'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                if ((remain_q != '0) && (used < USE_W'(RD_FIFO_DEPTH))) begin
                    avm_chipselect_d = 1'b1;
                    avm_address_d    = addr_q;
                    addr_d           = addr_q + 1'b1;
                    remain_d         = remain_q - 1'b1;
                    if (remain_q == (ADDR_W+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((inflight == '0) && pop && (fifo_cnt_q == CNT_W'(1))) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            remain_q         <= '0;
            avm_address_q    <= '0;
            avm_writedata_q  <= '0;
            avm_chipselect_q <= 1'b0;
            avm_write_q      <= 1'b0;
            done_q           <= 1'b0;
            lat_q            <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fifo_cnt_q       <= '0;
        end else begin
            state_q          <= state_d;
            addr_q           <= addr_d;
            remain_q         <= remain_d;
            avm_address_q    <= avm_address_d;
            avm_writedata_q  <= avm_writedata_d;
            avm_chipselect_q <= avm_chipselect_d;
            avm_write_q      <= avm_write_d;
            done_q           <= done_d;
            lat_q            <= lat_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            fifo_cnt_q       <= fifo_cnt_d;
        end
    end

    assign bus.cmd_ready      = (state_q == IDLE);
    assign bus.wr_ready       = (state_q == WRITE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.done           = done_q | drain_done;
    assign bus.rd_valid       = (fifo_cnt_q != '0);
    assign bus.rd_data        = fifo_mem[rd_ptr_q];
    assign bus.avm_address    = avm_address_q;
    assign bus.avm_chipselect = avm_chipselect_q;
    assign bus.avm_write      = avm_write_q;
    assign bus.avm_writedata  = avm_writedata_q;
    assign bus.avm_byteenable = '1;
    assign bus.avm_clken      = 1'b1;
endmodule

// File: tb/tb_pacman_soc_mem_burst_master.sv
// Directed bench for the memory burst master: a latency-1 memory model on the bus,
// scoreboard queues for bus writes and returned read words.
module tb_pacman_soc_mem_burst_master;
    logic clk;
    logic reset;

    pacman_soc_mem_burst_master_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    pacman_soc_mem_burst_master #(
        .ADDR_W(10), .DATA_W(32), .READ_LATENCY(1), .RD_FIFO_DEPTH(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory slave model: one-cycle read latency, no waitrequest.
    logic [31:0] slave_mem [1024];
    logic [31:0] slave_rdata;
    always @(posedge clk) begin
        if (bus.avm_chipselect && bus.avm_write) slave_mem[bus.avm_address] <= bus.avm_writedata;
        if (bus.avm_chipselect && !bus.avm_write) slave_rdata <= slave_mem[bus.avm_address];
    end
    assign bus.avm_readdata = slave_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [41:0] exp_wr[$];
    logic [31:0] exp_rd[$];
    logic [31:0] ref_mem [1024];
    int          touch_wr [1024];
    int          touch_rd [1024];
    int          issued = 0, popped = 0, done_cnt = 0, wr_seen = 0, rd_seen = 0;
    logic        done_now, valid_now;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Negedge snapshot: scoreboard the bus and the read stream.
    task automatic sample();
        logic [41:0] e;
        @(negedge clk);
        done_now  = bus.done;
        valid_now = bus.rd_valid;
        if (reset) begin
            exp_rd.delete();
            exp_wr.delete();
            issued = 0;
            popped = 0;
        end else begin
            if (bus.done) done_cnt++;
            if (bus.avm_chipselect && bus.avm_write) begin
                wr_seen++;
                touch_wr[bus.avm_address]++;
                check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(bus.avm_address), 32'(e[41:32]));
                    check("wr_data", bus.avm_writedata, e[31:0]);
                end
            end
            if (bus.avm_chipselect && !bus.avm_write) begin
                rd_seen++;
                issued++;
                touch_rd[bus.avm_address]++;
                check("outstanding_le4", 32'((issued - popped) <= 4), 32'd1);
            end
            if (bus.rd_valid && bus.rd_ready) begin
                check("rd_expected", 32'(exp_rd.size() != 0), 32'd1);
                if (exp_rd.size() != 0) check("rd_data", bus.rd_data, exp_rd.pop_front());
                popped++;
            end
        end
    endtask

    task automatic step();
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [9:0] a, input int len, input logic [31:0] seed,
                            input logic [31:0] stride);
        logic [9:0] ad;
        logic [31:0] d;
        int d0;
        for (int i = 0; i < len; i++) begin
            ad = a + 10'(i);
            d  = seed + stride * 32'(i);
            exp_wr.push_back({ad, d});
            ref_mem[ad] = d;
        end
        $display("write burst addr=%h len=%0d", a, len);
        d0 = done_cnt;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = a; bus.cmd_len = 11'(len);
        bus.wr_valid = 1'b1; bus.wr_data = seed;
        step();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            bus.wr_data = seed + stride * 32'(i);
            step();
            check("wr_strobe", 32'({bus.avm_chipselect, bus.avm_write}), 32'd3);
            check("wr_done", 32'(bus.done), 32'(i == len - 1));
        end
        step();
        check("wr_after_cs", 32'(bus.avm_chipselect), 32'd0);
        check("wr_after_done", 32'(bus.done), 32'd0);
        check("wr_after_busy", 32'(bus.busy), 32'd0);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        check("wr_done_count", 32'(done_cnt - d0), 32'd1);
        bus.wr_valid = 1'b0;
    endtask

    // mode 0: rd_ready high; 1: high one cycle in three with cmd_valid offered while busy; 2: random.
    task automatic do_read(input logic [9:0] a, input int len, input int mode,
                           output int done_k, output int first_k);
        int d0;
        for (int i = 0; i < len; i++) exp_rd.push_back(ref_mem[a + 10'(i)]);
        $display("read burst addr=%h len=%0d mode=%0d", a, len, mode);
        d0 = done_cnt;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = a; bus.cmd_len = 11'(len);
        step();
        bus.cmd_valid = 1'b0;
        done_k  = -1;
        first_k = -1;
        for (int k = 0; k < len * 4 + 20; k++) begin
            case (mode)
                0:       bus.rd_ready = 1'b1;
                1:       bus.rd_ready = ((k % 3) == 0);
                default: bus.rd_ready = 1'($urandom_range(0, 1));
            endcase
            bus.cmd_valid = (mode == 1) && (k < 10);
            bus.cmd_write = 1'b1; bus.cmd_addr = 10'h055; bus.cmd_len = 11'd7;
            step();
            if (valid_now && first_k < 0) first_k = k;
            if (done_now) begin
                done_k = k;
                break;
            end
        end
        bus.cmd_valid = 1'b0;
        check("rd_done_seen", 32'(done_k >= 0), 32'd1);
        check("rd_all_returned", 32'(exp_rd.size()), 32'd0);
        check("rd_after_busy", 32'(bus.busy), 32'd0);
        check("rd_after_valid", 32'(bus.rd_valid), 32'd0);
        check("rd_after_done", 32'(bus.done), 32'd0);
        check("rd_done_count", 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        int dk, fk, d0, w0, r0, p0, bad;
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_data = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        @(posedge clk);
        #1;
        step();
        step();
        check("rst_cs", 32'(bus.avm_chipselect), 32'd0);
        check("rst_write", 32'(bus.avm_write), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_addr", 32'(bus.avm_address), 32'd0);
        check("rst_wdata", bus.avm_writedata, 32'd0);
        check("byteenable", 32'(bus.avm_byteenable), 32'hF);
        check("clken", 32'(bus.avm_clken), 32'd1);
        reset = 1'b0;
        step();
        check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        do_write(10'h3FE, 4, 32'h0000_00A0, 32'h1);
        do_read(10'h3FE, 4, 0, dk, fk);
        check("rb_first_valid", 32'(fk), 32'd3);
        check("rb_done_cycle", 32'(dk), 32'd6);

        do_write(10'h100, 16, 32'h1000_0000, 32'h0001_0001);
        do_read(10'h100, 16, 1, dk, fk);
        check("bp_first_valid", 32'(fk), 32'd3);

        for (int w = 0; w < 2; w++) begin
            w0 = wr_seen; r0 = rd_seen; d0 = done_cnt;
            $display("zero-length command write=%0d", w);
            bus.cmd_valid = 1'b1; bus.cmd_write = (w == 1); bus.cmd_addr = 10'h123; bus.cmd_len = '0;
            step();
            bus.cmd_valid = 1'b0;
            check("zl_done", 32'(bus.done), 32'd1);
            check("zl_cmd_ready", 32'(bus.cmd_ready), 32'd1);
            check("zl_busy", 32'(bus.busy), 32'd0);
            step();
            check("zl_done_clear", 32'(bus.done), 32'd0);
            check("zl_no_bus", 32'(wr_seen + rd_seen - w0 - r0), 32'd0);
            check("zl_done_count", 32'(done_cnt - d0), 32'd1);
        end

        $display("read burst addr=100 len=16 reset after 5 words");
        for (int i = 0; i < 16; i++) exp_rd.push_back(ref_mem[10'h100 + 10'(i)]);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 10'h100; bus.cmd_len = 11'd16;
        bus.rd_ready = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        p0 = popped;
        for (int k = 0; k < 40 && (popped - p0) < 5; k++) step();
        check("rm_five_popped", 32'(popped - p0), 32'd5);
        reset = 1'b1;
        d0 = done_cnt;
        step();
        check("rm_cs", 32'(bus.avm_chipselect), 32'd0);
        check("rm_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rm_busy", 32'(bus.busy), 32'd0);
        check("rm_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        step();
        step();
        step();
        check("rm_no_done", 32'(done_cnt - d0), 32'd0);
        check("rm_discarded", 32'(bus.rd_valid), 32'd0);
        do_read(10'h100, 2, 0, dk, fk);
        check("rm_new_done_cycle", 32'(dk), 32'd4);

        for (int i = 0; i < 1024; i++) begin
            touch_wr[i] = 0;
            touch_rd[i] = 0;
        end
        do_write(10'h200, 1024, 32'h5A5A_0000, 32'h9E37_79B1);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (touch_wr[i] != 1) bad++;
        check("full_wr_touch_once", 32'(bad), 32'd0);
        do_read(10'h200, 1024, 0, dk, fk);
        check("full_rd_done_cycle", 32'(dk), 32'd1026);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (touch_rd[i] != 1) bad++;
        check("full_rd_touch_once", 32'(bad), 32'd0);
        do_read(10'h3F0, 40, 2, dk, fk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
